mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single data-memory port between instruction fetch (IFU) and the load/store path (LSU) in the NPC core. Accepts one request at a time from either requester, arbitrates round-robin on ties, and sequences the request/response handshake to a multi-cycle memory. Returns the response to the owning requester as a one-cycle pulse. An optional watchdog aborts hung transactions.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles in REQ+WAIT before abort; used only with the timeout feature.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `ifu_req_valid` in 1: IFU read request.
- `ifu_req_ready` out 1: IFU request accepted this cycle.
- `ifu_addr` in `ISA_WIDTH`: IFU fetch address.
- `ifu_rsp_valid` out 1: one-cycle IFU response pulse.
- `ifu_rdata` out `ISA_WIDTH`: IFU read data.
- `ifu_rsp_err` out 1: IFU transaction aborted.
- `lsu_req_valid` in 1: LSU request.
- `lsu_req_ready` out 1: LSU request accepted this cycle.
- `lsu_addr` in `ISA_WIDTH`: LSU address.
- `lsu_wdata` in `ISA_WIDTH`: LSU store data.
- `lsu_wen` in 1: 1 = store, 0 = load.
- `lsu_rsp_valid` out 1: one-cycle LSU response pulse.
- `lsu_rdata` out `ISA_WIDTH`: LSU load data; 0 for stores.
- `lsu_rsp_err` out 1: LSU transaction aborted.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_addr` out `ISA_WIDTH`: memory address.
- `mem_wdata` out `ISA_WIDTH`: memory write data.
- `mem_wen` out 1: memory write enable.
- `mem_rsp_valid` in 1: memory response valid.
- `mem_rdata` in `ISA_WIDTH`: memory read data.

## Operation
- FSM states:
  - IDLE: `*_req_ready` are combinational. Only the winner sees ready=1, and only when its valid=1. On handshake, latch owner, addr, wdata and wen (IFU: wdata=0, wen=0), then go to REQ.
  - REQ: `mem_req_valid`=1 with latched fields, held stable. When `mem_req_ready`=1, go to WAIT.
  - WAIT: when `mem_rsp_valid`=1, latch `mem_rdata` and go to RESP.
  - RESP: owner's `*_rsp_valid`=1 for exactly one cycle with latched data, then go to IDLE.
- Arbitration:
  - Single valid request: it is granted.
  - Both valid: grant the requester not granted last.
  - `last_owner` resets to LSU, so IFU wins the first tie.
- Response data: for stores, `lsu_rdata` = 0 regardless of `mem_rdata`.
- Ignored inputs: `mem_rsp_valid` outside WAIT, and any `*_req_valid` outside IDLE. Requesters hold valid until ready.
- No response back-pressure: requesters must take the pulse.
- Reset values: all valid/ready/err outputs 0; `mem_addr`=`BASE_ADDR`; `mem_wdata`=0; `mem_wen`=0; rdata outputs 0; state IDLE; `last_owner`=LSU.
- Reset mid-operation: the in-flight transaction is dropped with no response pulse; state returns to IDLE next cycle. Memory must tolerate the dropped request.

## Timing
- Request handshake at cycle t → `mem_req_valid` high at t+1.
- Memory accepts at t+1 and responds at t+2 → `*_rsp_valid` at t+3.
- The next grant is possible at t+4; the arbiter is not pipelined and has one outstanding transaction.
- `mem_req_valid` stays high from t+1 through the cycle in which `mem_req_ready`=1.
- `mem_addr`, `mem_wdata` and `mem_wen` remain stable while `mem_req_valid` is high.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`, go to RESP with `*_rsp_err`=1 and rdata=0.
  - `mem_req_valid` drops on the abort.
  - A late `mem_rsp_valid` is then ignored.
- `MEM_ARB_TIMEOUT_EN` undefined: no counter; err outputs tied to 0; the FSM waits indefinitely.

## Structure
- Shared header alongside `config.vh` holds:
  - state encodings `ARB_IDLE`, `ARB_REQ`, `ARB_WAIT`, `ARB_RESP` with `ARB_STATE_WIDTH`;
  - owner encodings `ARB_OWNER_IFU`, `ARB_OWNER_LSU`.
- `ISA_WIDTH` and `BASE_ADDR` come from `config.vh`.
- One sub-module, `mem_arb_timer`: the watchdog counter with clear, enable and expired ports, instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- IFU-only read:
  - Stimulus: `ifu_addr`=0x80000004; memory ready immediately and responds next cycle with 0x00100073.
  - Required: `ifu_rsp_valid` at t+3 with `ifu_rdata`=0x00100073; `lsu_rsp_valid` stays 0.
- LSU store:
  - Stimulus: `lsu_addr`=0x80001000, `lsu_wdata`=0xDEADBEEF, `lsu_wen`=1.
  - Required: `mem_wen`=1 with matching addr/data; `lsu_rsp_valid` pulse with `lsu_rdata`=0.
- Tie after reset:
  - Stimulus: both requesters valid.
  - Required: IFU granted first, then LSU, then IFU again if both stay valid.
- Backpressure:
  - Stimulus: `mem_req_ready` held 0 for 5 cycles.
  - Required: `mem_req_valid` and `mem_addr` stable for all 6 cycles; a `mem_rsp_valid` glitch in REQ is ignored.
- Mid-transaction reset:
  - Stimulus: `rst` pulsed in WAIT.
  - Required: no response pulse; outputs at reset values next cycle; a later `mem_rsp_valid` is ignored.
- Timeout (with `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):
  - Stimulus: memory never responds.
  - Required: `lsu_rsp_err`=1 pulse after 8 cycles in REQ/WAIT, with rdata=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter definitions: datapath width, boot address, FSM state and owner encodings.
package mem_arbiter_pkg;

  localparam int ISA_WIDTH = 32;
  localparam logic [ISA_WIDTH-1:0] BASE_ADDR = 32'h8000_0000;

  localparam int ARB_STATE_WIDTH = 2;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_IDLE = 2'd0;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_REQ  = 2'd1;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_WAIT = 2'd2;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_RESP = 2'd3;

  localparam logic ARB_OWNER_IFU = 1'b0;
  localparam logic ARB_OWNER_LSU = 1'b1;

  typedef struct packed {
    logic [ISA_WIDTH-1:0] addr;
    logic [ISA_WIDTH-1:0] wdata;
    logic                 wen;
  } arb_req_t;

  // Stores return zero data to the requester whatever the memory drives.
  function automatic logic [ISA_WIDTH-1:0] load_data(input logic wen,
                                                     input logic [ISA_WIDTH-1:0] rdata);
    return wen ? '0 : rdata;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory handshakes around the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                 ifu_req_valid;
  logic                 ifu_req_ready;
  logic [ISA_WIDTH-1:0] ifu_addr;
  logic                 ifu_rsp_valid;
  logic [ISA_WIDTH-1:0] ifu_rdata;
  logic                 ifu_rsp_err;

  logic                 lsu_req_valid;
  logic                 lsu_req_ready;
  logic [ISA_WIDTH-1:0] lsu_addr;
  logic [ISA_WIDTH-1:0] lsu_wdata;
  logic                 lsu_wen;
  logic                 lsu_rsp_valid;
  logic [ISA_WIDTH-1:0] lsu_rdata;
  logic                 lsu_rsp_err;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [ISA_WIDTH-1:0] mem_addr;
  logic [ISA_WIDTH-1:0] mem_wdata;
  logic                 mem_wen;
  logic                 mem_rsp_valid;
  logic [ISA_WIDTH-1:0] mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    input  lsu_req_valid, lsu_addr, lsu_wdata, lsu_wen,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    output mem_req_valid, mem_addr, mem_wdata, mem_wen,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    output lsu_req_valid, lsu_addr, lsu_wdata, lsu_wen,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_addr, mem_wdata, mem_wen,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Watchdog counter for the arbiter: counts busy cycles and flags expiry at MAX_CYCLES.
module mem_arb_timer #(
  parameter int MAX_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(MAX_CYCLES + 1);

  logic [W-1:0] count;

  // The cycle holding count == MAX-1 is the MAX-th busy cycle since clear.
  assign expired = en && (count == W'(MAX_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin IFU/LSU arbiter for the single data-memory port, one transaction in flight.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst,
  mem_arbiter_if.master  bus
);

  logic [ARB_STATE_WIDTH-1:0] state;
  logic                       owner;
  logic                       last_owner;
  arb_req_t                   req_q;
  logic [ISA_WIDTH-1:0]       rdata_q;
  logic                       grant_ifu;
  logic                       grant_lsu;
  logic                       timer_expired;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == ARB_IDLE) begin
      if (bus.ifu_req_valid && (!bus.lsu_req_valid || last_owner == ARB_OWNER_LSU)) begin
        grant_ifu = 1'b1;
      end else if (bus.lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  assign bus.ifu_req_ready = grant_ifu;
  assign bus.lsu_req_ready = grant_lsu;

`ifdef MEM_ARB_TIMEOUT_EN
  logic timer_busy;
  logic err_q;

  assign timer_busy = (state == ARB_REQ) || (state == ARB_WAIT);

  mem_arb_timer #(
    .MAX_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_ifu || grant_lsu),
    .en      (timer_busy),
    .expired (timer_expired)
  );

  // A genuine response arriving in the expiry cycle wins over the abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == ARB_IDLE) begin
      err_q <= 1'b0;
    end else if (timer_expired && !(state == ARB_WAIT && bus.mem_rsp_valid)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.ifu_rsp_err = (state == ARB_RESP) && (owner == ARB_OWNER_IFU) && err_q;
  assign bus.lsu_rsp_err = (state == ARB_RESP) && (owner == ARB_OWNER_LSU) && err_q;
`else
  assign timer_expired   = 1'b0;
  assign bus.ifu_rsp_err = 1'b0;
  assign bus.lsu_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= ARB_OWNER_LSU;
      last_owner <= ARB_OWNER_LSU;
      req_q      <= '{addr: BASE_ADDR, wdata: '0, wen: 1'b0};
      rdata_q    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_ifu) begin
            owner      <= ARB_OWNER_IFU;
            last_owner <= ARB_OWNER_IFU;
            req_q      <= '{addr: bus.ifu_addr, wdata: '0, wen: 1'b0};
            state      <= ARB_REQ;
          end else if (grant_lsu) begin
            owner      <= ARB_OWNER_LSU;
            last_owner <= ARB_OWNER_LSU;
            req_q      <= '{addr: bus.lsu_addr, wdata: bus.lsu_wdata, wen: bus.lsu_wen};
            state      <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (timer_expired) begin
            rdata_q <= '0;
            state   <= ARB_RESP;
          end else if (bus.mem_req_ready) begin
            state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.mem_rsp_valid) begin
            rdata_q <= load_data(req_q.wen, bus.mem_rdata);
            state   <= ARB_RESP;
          end else if (timer_expired) begin
            rdata_q <= '0;
            state   <= ARB_RESP;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_valid = (state == ARB_REQ);
  assign bus.mem_addr      = req_q.addr;
  assign bus.mem_wdata     = req_q.wdata;
  assign bus.mem_wen       = req_q.wen;

  assign bus.ifu_rsp_valid = (state == ARB_RESP) && (owner == ARB_OWNER_IFU);
  assign bus.lsu_rsp_valid = (state == ARB_RESP) && (owner == ARB_OWNER_LSU);
  assign bus.ifu_rdata     = rdata_q;
  assign bus.lsu_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions, responses checked by a monitor.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic        lsu;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  mem_arbiter_if bus();

  mem_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (bus.ifu_rsp_valid || bus.lsu_rsp_valid)) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_lsu_valid", 32'(bus.lsu_rsp_valid), 32'(e.lsu));
        check("rsp_ifu_valid", 32'(bus.ifu_rsp_valid), 32'(!e.lsu));
        check("rsp_rdata", e.lsu ? bus.lsu_rdata : bus.ifu_rdata, e.rdata);
        check("rsp_err", 32'(e.lsu ? bus.lsu_rsp_err : bus.ifu_rsp_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wdata     = '0;
    bus.lsu_wen       = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  task automatic grant(input bit exp_lsu, input logic [31:0] exp_rdata, input bit exp_err,
                       input bit expect_rsp, input string tag);
    @(negedge clk);
    check({tag, "_ifu_ready"}, 32'(bus.ifu_req_ready), 32'(!exp_lsu));
    check({tag, "_lsu_ready"}, 32'(bus.lsu_req_ready), 32'(exp_lsu));
    if (expect_rsp) sb.push_back('{exp_lsu, exp_rdata, exp_err});
    tick();
  endtask

  // Drives memory from the first REQ cycle through RESP; stall = cycles of ready low.
  task automatic serve(input bit own_lsu, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit wen, input logic [31:0] mem_data, input int stall,
                       input string tag);
    for (int i = 0; i <= stall; i++) begin
      bus.mem_req_ready = (i == stall);
      bus.mem_rsp_valid = (i == 2);
      bus.mem_rdata     = (i == 2) ? 32'hBAD0_BAD0 : 32'h0;
      @(negedge clk);
      check({tag, "_mem_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
      check({tag, "_mem_addr"}, bus.mem_addr, addr);
      if (i == 0) begin
        check({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
        check({tag, "_mem_wen"}, 32'(bus.mem_wen), 32'(wen));
      end
      tick();
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = mem_data;
    @(negedge clk);
    check({tag, "_req_dropped"}, 32'(bus.mem_req_valid), 32'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'hFFFF_FFFF;
    @(negedge clk);
    check({tag, "_rsp_timing"}, 32'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}),
          own_lsu ? 32'd1 : 32'd2);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "tb_mem_arbiter timed out");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_mem_addr", bus.mem_addr, BASE_ADDR);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
    check("rst_rsp_valid", 32'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 32'd0);
    check("rst_rsp_err", 32'({bus.ifu_rsp_err, bus.lsu_rsp_err}), 32'd0);
    check("rst_rdata", bus.ifu_rdata | bus.lsu_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // IFU-only read
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0004;
    grant(1'b0, 32'h0010_0073, 1'b0, 1'b1, "ifu_read");
    bus.ifu_req_valid = 1'b0;
    serve(1'b0, 32'h8000_0004, 32'h0, 1'b0, 32'h0010_0073, 0, "ifu_read");

    // LSU store: response data forced to zero
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wen       = 1'b1;
    grant(1'b1, 32'h0, 1'b0, 1'b1, "lsu_store");
    bus.lsu_req_valid = 1'b0;
    serve(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 0, "lsu_store");

    // LSU load under 5 cycles of memory backpressure with a response glitch in REQ
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_2000;
    bus.lsu_wdata     = 32'h0;
    bus.lsu_wen       = 1'b0;
    grant(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, "bp");
    bus.lsu_req_valid = 1'b0;
    serve(1'b1, 32'h8000_2000, 32'h0, 1'b0, 32'hCAFE_F00D, 5, "bp");

    // Tie after reset: IFU, LSU, IFU
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0010;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_3000;
    bus.lsu_wdata     = 32'h5555_AAAA;
    bus.lsu_wen       = 1'b0;
    grant(1'b0, 32'h1111_1111, 1'b0, 1'b1, "tie1");
    serve(1'b0, 32'h8000_0010, 32'h0, 1'b0, 32'h1111_1111, 0, "tie1");
    grant(1'b1, 32'h2222_2222, 1'b0, 1'b1, "tie2");
    serve(1'b1, 32'h8000_3000, 32'h5555_AAAA, 1'b0, 32'h2222_2222, 0, "tie2");
    grant(1'b0, 32'h3333_3333, 1'b0, 1'b1, "tie3");
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    serve(1'b0, 32'h8000_0010, 32'h0, 1'b0, 32'h3333_3333, 0, "tie3");

    // Reset while waiting on memory: transaction dropped silently
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0020;
    grant(1'b0, 32'h0, 1'b0, 1'b0, "rst_mid");
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_req_valid", 32'(bus.mem_req_valid), 32'd1);
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_wait", 32'(bus.mem_req_valid), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_addr", bus.mem_addr, BASE_ADDR);
    check("rst_mid_rsp_valid", 32'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 32'd0);
    check("rst_mid_rdata", bus.ifu_rdata, 32'd0);
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h7777_7777;
    @(negedge clk);
    check("rst_mid_late_rsp", 32'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 32'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_late_rsp2", 32'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 32'd0);
    check("rst_mid_rdata2", bus.ifu_rdata, 32'd0);
    tick();

    // Recovery after the dropped transaction
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0040;
    grant(1'b0, 32'h0BAD_F00D, 1'b0, 1'b1, "recover");
    bus.ifu_req_valid = 1'b0;
    serve(1'b0, 32'h8000_0040, 32'h0, 1'b0, 32'h0BAD_F00D, 1, "recover");

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int n;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = 32'h8000_4000;
      bus.lsu_wen       = 1'b0;
      grant(1'b1, 32'h0, 1'b1, 1'b1, "timeout");
      bus.lsu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      for (n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (bus.lsu_rsp_valid) break;
        tick();
        bus.mem_req_ready = 1'b0;
      end
      check("timeout_cycles", 32'(n), 32'd9);
      tick();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = 32'h9999_9999;
      @(negedge clk);
      check("timeout_late_rsp", 32'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 32'd0);
      check("timeout_req_valid", 32'(bus.mem_req_valid), 32'd0);
      tick();
      bus.mem_rsp_valid = 1'b0;
    end
`endif

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
